counter_cmd_sequencer: RTL

Command front-end for `load_counter`. Accepts opcode commands over a valid/ready handshake and drives the counter's `load`, `load_en`, `upordown`, `start` and `continue_1` inputs with the correct level and strobe sequencing. It also watches the counter's `pulse` output so it can run the counter for an exact number of terminal pulses and then stop it. It sits directly upstream of `load_counter`; its outputs wire 1:1 to that block's same-named inputs.

---
 rtl/counter_cmd_sequencer_if.sv | 14 +
 rtl/counter_cmd_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bundle between a command source and counter_cmd_sequencer.
// The master drives opcode/data/direction with valid; the slave answers with ready.
interface counter_cmd_sequencer_if #(
  parameter int LOAD_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [LOAD_WIDTH-1:0] cmd_data;
  logic                  cmd_dir;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_dir, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_dir, output cmd_ready);
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Opcode front-end for load_counter: sequences load/start/continue levels and
// optionally runs the counter for an exact number of terminal pulses.
module counter_cmd_sequencer #(
  parameter int LOAD_WIDTH   = 32,
  parameter int BUDGET_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  counter_cmd_sequencer_if.slave  cmd,
  input  logic                    pulse,
  output logic [LOAD_WIDTH-1:0]   load,
  output logic                    load_en,
  output logic                    upordown,
  output logic                    start,
  output logic                    continue_1,
  output logic [1:0]              state,
  output logic [BUDGET_WIDTH-1:0] remaining,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LOADING = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CONFIG = 3'd1,
    OP_START  = 3'd2,
    OP_STOP   = 3'd3,
    OP_PAUSE  = 3'd4,
    OP_RESUME = 3'd5,
    OP_RUN_N  = 3'd6,
    OP_RSVD   = 3'd7
  } op_t;

  state_t                  r_state;
  logic [LOAD_WIDTH-1:0]   r_load;
  logic                    r_load_en;
  logic                    r_upordown;
  logic                    r_start;
  logic                    r_cont;
  logic [BUDGET_WIDTH-1:0] r_rem;
  logic                    r_done;
  logic                    r_err;

  logic                    w_acc;
  logic                    w_cnt;
  logic                    w_final;
  logic [BUDGET_WIDTH-1:0] w_budget;
  op_t                     w_op;

  assign cmd.cmd_ready = (r_state != ST_LOADING);
  assign w_acc         = cmd.cmd_valid & cmd.cmd_ready;
  assign w_op          = op_t'(cmd.cmd_op);
  assign w_budget      = cmd.cmd_data[BUDGET_WIDTH-1:0];
  // Only a budgeted run consumes pulses; the last one forces a stop.
  assign w_cnt         = (r_state == ST_RUNNING) && pulse && (r_rem != '0);
  assign w_final       = w_cnt && (r_rem == BUDGET_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_STOPPED;
      r_load     <= '0;
      r_load_en  <= 1'b0;
      r_upordown <= 1'b1;
      r_start    <= 1'b0;
      r_cont     <= 1'b0;
      r_rem      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_load_en <= 1'b0;
      if (w_cnt) r_rem <= r_rem - 1'b1;

      if (w_final) begin
        // Exhaustion wins over any concurrent command; STOP is absorbed quietly.
        r_state <= ST_STOPPED;
        r_start <= 1'b0;
        r_cont  <= 1'b0;
        r_done  <= 1'b1;
        r_err   <= w_acc && (w_op != OP_NOP) && (w_op != OP_STOP);
      end else begin
        case (r_state)
          ST_LOADING: r_state <= ST_STOPPED;
          ST_STOPPED: if (w_acc) begin
            case (w_op)
              OP_NOP: ;
              OP_CONFIG: begin
                r_state    <= ST_LOADING;
                r_load     <= cmd.cmd_data;
                r_upordown <= cmd.cmd_dir;
                r_load_en  <= 1'b1;
              end
              OP_START: begin
                r_state <= ST_RUNNING;
                r_start <= 1'b1;
                r_cont  <= 1'b1;
                r_rem   <= '0;
              end
              OP_RUN_N: begin
                if (w_budget != '0) begin
                  r_state <= ST_RUNNING;
                  r_start <= 1'b1;
                  r_cont  <= 1'b1;
                  r_rem   <= w_budget;
                end else begin
                  r_err <= 1'b1;
                end
              end
              default: r_err <= 1'b1;
            endcase
          end
          ST_RUNNING: if (w_acc) begin
            case (w_op)
              OP_NOP: ;
              OP_STOP: begin
                r_state <= ST_STOPPED;
                r_start <= 1'b0;
                r_cont  <= 1'b0;
                r_rem   <= '0;
              end
              OP_PAUSE: begin
                r_state <= ST_PAUSED;
                r_cont  <= 1'b0;
              end
              default: r_err <= 1'b1;
            endcase
          end
          ST_PAUSED: if (w_acc) begin
            case (w_op)
              OP_NOP: ;
              OP_STOP: begin
                r_state <= ST_STOPPED;
                r_start <= 1'b0;
                r_cont  <= 1'b0;
                r_rem   <= '0;
              end
              OP_RESUME: begin
                r_state <= ST_RUNNING;
                r_cont  <= 1'b1;
              end
              default: r_err <= 1'b1;
            endcase
          end
          default: r_state <= ST_STOPPED;
        endcase
      end
    end
  end

  assign load       = r_load;
  assign load_en    = r_load_en;
  assign upordown   = r_upordown;
  assign start      = r_start;
  assign continue_1 = r_cont;
  assign state      = r_state;
  assign remaining  = r_rem;
  assign done       = r_done;
  assign err        = r_err;

endmodule
